// File: rtl/pc_target_table.sv
// Run-time programmable branch-target table with registered lookup, PC-relative
// entries, write-through forwarding and a sequential re-init sweep to identity.
module pc_target_table #(
    parameter int IDX_W = 5,
    parameter int VAL_W = 10
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             init_req,
    output logic             busy,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [VAL_W-1:0] wr_val,
    input  logic             wr_rel,
    output logic             wr_err,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [VAL_W-1:0] pc_in,
    output logic [VAL_W-1:0] target,
    output logic             target_vld
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               wr_err_q, wr_err_d;
    logic               target_vld_q, target_vld_d;
    logic [VAL_W-1:0]   target_q, target_d;

    logic [VAL_W-1:0]   tbl_val_q [DEPTH];
    logic               tbl_rel_q [DEPTH];

    logic               tbl_we_s;
    logic [IDX_W-1:0]   tbl_idx_s;
    logic [VAL_W-1:0]   tbl_val_s;
    logic               tbl_rel_s;
    logic [VAL_W-1:0]   ent_val_s;
    logic               ent_rel_s;

    // Relative entries hold a two's-complement offset; the add wraps mod 2**VAL_W.
    function automatic logic [VAL_W-1:0] resolve(input logic             rel,
                                                 input logic [VAL_W-1:0] val,
                                                 input logic [VAL_W-1:0] pc);
        if (rel) begin
            resolve = pc + val;
        end else begin
            resolve = val;
        end
    endfunction

    // Sequencer next state and the single table write port it arbitrates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tbl_we_s  = 1'b0;
        tbl_idx_s = wr_idx;
        tbl_val_s = wr_val;
        tbl_rel_s = wr_rel;
        wr_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A write in the same cycle as init_req still lands; the sweep overwrites it later.
                tbl_we_s = wr_en;
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                tbl_we_s  = 1'b1;
                tbl_idx_s = cnt_q;
                tbl_val_s = VAL_W'(cnt_q);
                tbl_rel_s = 1'b0;
                wr_err_d  = wr_en;
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == {IDX_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {IDX_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_INIT);
    end

    // Lookup path with write-through forwarding of a same-cycle write.
    always_comb begin
        if ((state_q == ST_IDLE) && wr_en && (wr_idx == rd_idx)) begin
            ent_val_s = wr_val;
            ent_rel_s = wr_rel;
        end else begin
            ent_val_s = tbl_val_q[rd_idx];
            ent_rel_s = tbl_rel_q[rd_idx];
        end
        if (rd_en && (state_q == ST_IDLE)) begin
            target_vld_d = 1'b1;
            target_d     = resolve(ent_rel_s, ent_val_s, pc_in);
        end else begin
            target_vld_d = 1'b0;
            target_d     = target_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {IDX_W{1'b0}};
            busy_q       <= 1'b0;
            wr_err_q     <= 1'b0;
            target_vld_q <= 1'b0;
            target_q     <= {VAL_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            wr_err_q     <= wr_err_d;
            target_vld_q <= target_vld_d;
            target_q     <= target_d;
        end
    end

    // Table storage; reset restores identity even if a sweep was cut short.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_val_q[i] <= VAL_W'(i);
                tbl_rel_q[i] <= 1'b0;
            end
        end else if (tbl_we_s) begin
            tbl_val_q[tbl_idx_s] <= tbl_val_s;
            tbl_rel_q[tbl_idx_s] <= tbl_rel_s;
        end
    end

    assign busy       = busy_q;
    assign wr_err     = wr_err_q;
    assign target     = target_q;
    assign target_vld = target_vld_q;

endmodule

// File: tb/tb_pc_target_table.sv
// Directed bench for pc_target_table: vector table for lookups/writes, plus
// hand-written sequences for the re-init sweep and reset during a sweep.
module tb_pc_target_table;

    localparam int IDX_W = 5;
    localparam int VAL_W = 10;

    logic             clk;
    logic             rst_n;
    logic             init_req;
    logic             busy;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [VAL_W-1:0] wr_val;
    logic             wr_rel;
    logic             wr_err;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [VAL_W-1:0] pc_in;
    logic [VAL_W-1:0] target;
    logic             target_vld;

    int checks = 0;
    int errors = 0;

    pc_target_table #(.IDX_W(IDX_W), .VAL_W(VAL_W)) dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .init_req   (init_req),
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_val     (wr_val),
        .wr_rel     (wr_rel),
        .wr_err     (wr_err),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .pc_in      (pc_in),
        .target     (target),
        .target_vld (target_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rd_en;
        logic [IDX_W-1:0] rd_idx;
        logic             wr_en;
        logic [IDX_W-1:0] wr_idx;
        logic [VAL_W-1:0] wr_val;
        logic             wr_rel;
        logic [VAL_W-1:0] pc_in;
        logic             exp_vld;
        logic [VAL_W-1:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic re, input int ri, input logic we, input int wi,
                                input int wv, input logic wrel, input int pc,
                                input logic ev, input int et);
        vec_t v;
        v.rd_en   = re;
        v.rd_idx  = IDX_W'(ri);
        v.wr_en   = we;
        v.wr_idx  = IDX_W'(wi);
        v.wr_val  = VAL_W'(wv);
        v.wr_rel  = wrel;
        v.pc_in   = VAL_W'(pc);
        v.exp_vld = ev;
        v.exp_tgt = VAL_W'(et);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        init_req = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_val   = '0;
        wr_rel   = 1'b0;
        rd_en    = 1'b0;
        rd_idx   = '0;
        pc_in    = '0;
    endtask

    // Drive one read of idx on the next edge and check the result.
    task automatic read_check(input string name, input int idx, input int exp);
        @(negedge clk);
        idle_inputs();
        rd_en  = 1'b1;
        rd_idx = IDX_W'(idx);
        @(posedge clk);
        #1;
        check({name, "_vld"}, int'(target_vld), 1);
        check(name, int'(target), exp);
    endtask

    initial begin
        int n;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_wr_err", int'(wr_err), 0);
        check("rst_target", int'(target), 0);
        check("rst_vld", int'(target_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) vecs.push_back(mk(1'b1, i, 1'b0, 0, 0, 1'b0, 0, 1'b1, i));
        vecs.push_back(mk(1'b0, 0,  1'b1, 5,  72,    1'b0, 0,     1'b0, 31));
        vecs.push_back(mk(1'b1, 5,  1'b0, 0,  0,     1'b0, 0,     1'b1, 72));
        vecs.push_back(mk(1'b1, 6,  1'b1, 6,  70,    1'b0, 0,     1'b1, 70));
        vecs.push_back(mk(1'b1, 6,  1'b0, 0,  0,     1'b0, 0,     1'b1, 70));
        vecs.push_back(mk(1'b0, 0,  1'b1, 25, 'h3F0, 1'b1, 0,     1'b0, 70));
        vecs.push_back(mk(1'b1, 25, 1'b0, 0,  0,     1'b0, 'h008, 1'b1, 'h3F8));
        vecs.push_back(mk(1'b1, 25, 1'b0, 0,  0,     1'b0, 'h020, 1'b1, 'h010));
        vecs.push_back(mk(1'b1, 7,  1'b1, 7,  'h005, 1'b1, 'h3FE, 1'b1, 'h003));
        vecs.push_back(mk(1'b1, 5,  1'b0, 0,  0,     1'b0, 'h100, 1'b1, 72));
        vecs.push_back(mk(1'b1, 31, 1'b0, 0,  0,     1'b0, 0,     1'b1, 31));
        vecs.push_back(mk(1'b1, 0,  1'b0, 0,  0,     1'b0, 0,     1'b1, 0));
        vecs.push_back(mk(1'b1, 31, 1'b0, 0,  0,     1'b0, 0,     1'b1, 31));
        vecs.push_back(mk(1'b0, 0,  1'b0, 0,  0,     1'b0, 0,     1'b0, 31));
        vecs.push_back(mk(1'b1, 3,  1'b1, 0,  'h001, 1'b1, 0,     1'b1, 3));
        vecs.push_back(mk(1'b1, 0,  1'b0, 0,  0,     1'b0, 'h3FF, 1'b1, 'h000));

        foreach (vecs[k]) begin
            @(negedge clk);
            init_req = 1'b0;
            rd_en    = vecs[k].rd_en;
            rd_idx   = vecs[k].rd_idx;
            wr_en    = vecs[k].wr_en;
            wr_idx   = vecs[k].wr_idx;
            wr_val   = vecs[k].wr_val;
            wr_rel   = vecs[k].wr_rel;
            pc_in    = vecs[k].pc_in;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_vld", k), int'(target_vld), int'(vecs[k].exp_vld));
            check($sformatf("vec%0d_tgt", k), int'(target), int'(vecs[k].exp_tgt));
        end

        // Re-init sweep with a same-cycle write, a dropped write, a blocked read and an ignored init_req.
        @(negedge clk);
        idle_inputs();
        init_req = 1'b1;
        wr_en    = 1'b1;
        wr_idx   = IDX_W'(5);
        wr_val   = VAL_W'(99);
        @(posedge clk);
        #1;
        check("init_busy_rise", int'(busy), 1);
        check("init_wr_err_idle", int'(wr_err), 0);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            idle_inputs();
            wr_en    = (n == 4);
            wr_idx   = IDX_W'(2);
            wr_val   = VAL_W'('h155);
            rd_en    = (n == 6);
            rd_idx   = IDX_W'(5);
            init_req = (n == 8);
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d_wr_err", n), int'(wr_err), int'(n == 4));
            check($sformatf("sweep%0d_vld", n), int'(target_vld), 0);
            if (busy) n++;
            else break;
        end
        check("sweep_busy_cycles", n, 32);
        read_check("post_sweep_rd5", 5, 5);
        read_check("post_sweep_rd6", 6, 6);
        read_check("post_sweep_rd25", 25, 25);
        read_check("post_sweep_rd2", 2, 2);
        read_check("post_sweep_rd0", 0, 0);

        // Reset asserted partway through a sweep.
        @(negedge clk);
        idle_inputs();
        wr_en  = 1'b1;
        wr_idx = IDX_W'(20);
        wr_val = VAL_W'('h123);
        read_check("pre_rst_rd20", 20, 'h123);
        @(negedge clk);
        idle_inputs();
        init_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_sweep_busy", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_vld", int'(target_vld), 0);
        check("mid_rst_target", int'(target), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_rst_busy", int'(busy), 0);
        read_check("after_rst_rd20", 20, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
